// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the two-wire bus sequencer.
// Imported by the sequencer top and anything that decodes its state.
package serial_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_XFER,
        S_ACK,
        S_STOP,
        S_DONE
    } sbs_state_t;

    localparam int SBS_BITS_PER_BYTE = 8;

    function automatic int sbs_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_bus_sequencer.sv
// Write-only two-wire transaction sequencer: START, N bytes + ACK slots, STOP.
// Paced entirely by phase strobes from an external slow clock generator.
module serial_bus_sequencer
    import serial_bus_pkg::*;
#(
    parameter int NBYTES = 3,
    parameter int DW     = 24
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [DW-1:0] data,
    output logic          ready,
    output logic          done,
    output logic          ack_error,
    output logic          enable_clk,
    input  logic          new_clk,
    input  logic          rising_edge,
    input  logic          falling_edge,
    input  logic          middle_of_high_level,
    input  logic          middle_of_low_level,
    output logic          scl,
    output logic          sda_oe,
    input  logic          sda_in
);

    localparam int BCW = sbs_cnt_w(NBYTES);

    sbs_state_t    state, state_n;
    logic [DW-1:0] shreg, shreg_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [BCW-1:0] byte_cnt, byte_cnt_n;
    // Sub-step within START / XFER / STOP
    logic [1:0]    phase, phase_n;
    logic          ready_n, done_n, ack_err_n, en_n, scl_n, oe_n;

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        byte_cnt_n = byte_cnt;
        phase_n    = phase;
        ready_n    = ready;
        done_n     = 1'b0;
        ack_err_n  = ack_error;
        en_n       = enable_clk;
        scl_n      = scl;
        oe_n       = sda_oe;
        unique case (state)
            S_IDLE: begin
                scl_n   = 1'b1;
                oe_n    = 1'b0;
                en_n    = 1'b0;
                ready_n = 1'b1;
                phase_n = 2'd0;
                if (ready && start) begin
                    shreg_n    = data;
                    byte_cnt_n = BCW'(NBYTES - 1);
                    bit_cnt_n  = 3'(SBS_BITS_PER_BYTE - 1);
                    ack_err_n  = 1'b0;
                    en_n       = 1'b1;
                    ready_n    = 1'b0;
                    state_n    = S_START;
                end
            end
            S_START: begin
                scl_n = 1'b1;
                if (phase == 2'd0) begin
                    if (middle_of_high_level) begin
                        oe_n    = 1'b1;
                        phase_n = 2'd1;
                    end
                end else if (falling_edge) begin
                    scl_n   = 1'b0;
                    phase_n = 2'd0;
                    state_n = S_XFER;
                end
            end
            S_XFER: begin
                scl_n = new_clk;
                if (middle_of_low_level) begin
                    if (phase[0]) begin
                        oe_n    = 1'b0;
                        phase_n = 2'd0;
                        state_n = S_ACK;
                    end else begin
                        oe_n    = ~shreg[DW-1];
                        shreg_n = {shreg[DW-2:0], 1'b0};
                        if (bit_cnt == 3'd0) phase_n = 2'd1;
                        else bit_cnt_n = bit_cnt - 3'd1;
                    end
                end
            end
            S_ACK: begin
                scl_n = new_clk;
                if (middle_of_high_level) begin
                    if (sda_in) begin
                        ack_err_n = 1'b1;
                        state_n   = S_STOP;
                    end else if (byte_cnt != '0) begin
                        byte_cnt_n = byte_cnt - 1'b1;
                        bit_cnt_n  = 3'(SBS_BITS_PER_BYTE - 1);
                        state_n    = S_XFER;
                    end else begin
                        state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Pull SDA low in the low phase, release SCL, then release SDA
                if (phase == 2'd0) begin
                    scl_n = new_clk;
                    if (middle_of_low_level) begin
                        oe_n    = 1'b1;
                        phase_n = 2'd1;
                    end
                end else if (phase == 2'd1) begin
                    scl_n = new_clk;
                    if (rising_edge) begin
                        scl_n   = 1'b1;
                        phase_n = 2'd2;
                    end
                end else begin
                    scl_n = 1'b1;
                    if (middle_of_high_level) begin
                        oe_n    = 1'b0;
                        phase_n = 2'd0;
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                en_n    = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            phase      <= '0;
            ready      <= 1'b1;
            done       <= 1'b0;
            ack_error  <= 1'b0;
            enable_clk <= 1'b0;
            scl        <= 1'b1;
            sda_oe     <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            byte_cnt   <= byte_cnt_n;
            phase      <= phase_n;
            ready      <= ready_n;
            done       <= done_n;
            ack_error  <= ack_err_n;
            enable_clk <= en_n;
            scl        <= scl_n;
            sda_oe     <= oe_n;
        end
    end

endmodule

// File: tb/tb_serial_bus_sequencer.sv
// Bench for serial_bus_sequencer: clock generator, bus slave and
// a transaction-level monitor compared against expected byte streams.
module tb_serial_bus_sequencer;

    localparam int NB = 3;
    localparam int W  = 24;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] data = '0;
    logic ready, done, ack_error, enable_clk, scl, sda_oe;
    logic new_clk, rising_edge, falling_edge, mhi, mlo, sda_in;

    int checks = 0;
    int errors = 0;

    serial_bus_sequencer #(.NBYTES(NB), .DW(W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .data(data),
        .ready(ready),
        .done(done),
        .ack_error(ack_error),
        .enable_clk(enable_clk),
        .new_clk(new_clk),
        .rising_edge(rising_edge),
        .falling_edge(falling_edge),
        .middle_of_high_level(mhi),
        .middle_of_low_level(mlo),
        .scl(scl),
        .sda_oe(sda_oe),
        .sda_in(sda_in)
    );

    always #5 clk = ~clk;

    // Slow clock generator: 8 clk per bus period, high half first
    logic [2:0] ph = 3'd0;
    always @(posedge clk) ph <= enable_clk ? ph + 3'd1 : 3'd0;
    assign new_clk      = !enable_clk || (ph < 3'd4);
    assign rising_edge  = enable_clk && (ph == 3'd0);
    assign mhi          = enable_clk && (ph == 3'd2);
    assign falling_edge = enable_clk && (ph == 3'd4);
    assign mlo          = enable_clk && (ph == 3'd6);

    // Bus slave and monitor
    logic [3:0] ack_mask = 4'hF;
    logic slave_low = 1'b0;
    logic prev_scl = 1'b1;
    logic prev_oe = 1'b0;
    logic in_tx = 1'b0;
    logic line_at [0:63];
    logic oe_at [0:63];
    int rises = 0;
    int nfall = 0;
    int starts = 0;
    int done_cnt = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int done_cyc = 0;

    assign sda_in = ~(sda_oe | slave_low);

    always @(negedge clk) begin : mon
        int nf;
        int idx;
        cyc      <= cyc + 1;
        prev_scl <= scl;
        prev_oe  <= sda_oe;
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (!reset_n) begin
            in_tx     <= 1'b0;
            slave_low <= 1'b0;
        end else if (scl && prev_scl && !prev_oe && sda_oe) begin
            in_tx     <= 1'b1;
            nfall     <= 0;
            rises     <= 0;
            starts    <= starts + 1;
            slave_low <= 1'b0;
        end else if (in_tx) begin
            if (scl && prev_scl && prev_oe && !sda_oe) begin
                in_tx    <= 1'b0;
                stop_cyc <= cyc;
            end
            if (!prev_scl && scl && rises < 64) begin
                line_at[rises] <= ~(sda_oe | slave_low);
                oe_at[rises]   <= sda_oe;
                rises          <= rises + 1;
            end
            if (prev_scl && !scl) begin
                nf    = nfall + 1;
                idx   = nf / 9 - 1;
                nfall <= nf;
                slave_low <= (nf % 9 == 0) && (idx < 4) && ack_mask[idx[1:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_mask(input int nack);
        for (int b = 0; b < 4; b++) ack_mask[b] = (b != nack);
    endtask

    // Reference: bytes MSB-first, 9 pulses per byte sent, NACK ends early
    task automatic check_tx(input logic [W-1:0] d, input int nack);
        int ns;
        logic [7:0] got;
        logic [7:0] exp;
        logic [3:0] rel;
        ns = (nack < 0) ? NB : nack + 1;
        chk("pulses", 32'(rises - 1), 32'(9 * ns));
        rel = '0;
        for (int b = 0; b < ns; b++) begin
            for (int i = 0; i < 8; i++) got[7-i] = line_at[9*b+i];
            exp = 8'((d >> (8 * (NB - 1 - b))) & 24'hFF);
            chk($sformatf("byte%0d", b), 32'(got), 32'(exp));
            rel[b] = ~oe_at[9*b+8];
        end
        chk("ack_release", 32'(rel), 32'((1 << ns) - 1));
        chk("ack_error", 32'(ack_error), 32'(nack >= 0));
    endtask

    task automatic do_tx(input logic [W-1:0] d, input int nack,
                         input bit poke);
        bit ok;
        int d0;
        wait_ready(ok);
        chk("ready_wait", 32'(ok), 32'd1);
        set_mask(nack);
        data  = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("accept_ready", 32'(ready), 32'd0);
        chk("accept_en", 32'(enable_clk), 32'd1);
        start = 1'b0;
        d0 = done_cnt;
        if (poke) begin
            repeat (40) @(negedge clk);
            data  = '1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(ok);
        chk("done_seen", 32'(ok), 32'd1);
        check_tx(d, nack);
        @(negedge clk);
        chk("ready_back", 32'(ready), 32'd1);
        chk("done_width", 32'(done), 32'd0);
        chk("done_after_stop", 32'(done_cyc - stop_cyc), 32'd1);
        chk("done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        bit ok;
        int d0;
        int s0;
        logic [31:0] r;

        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_oe", 32'(sda_oe), 32'd0);
        chk("rst_en", 32'(enable_clk), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ackerr", 32'(ack_error), 32'd0);

        do_tx(24'h340C1F, -1, 1'b0);
        do_tx(24'h340C1F, 0, 1'b0);
        do_tx(24'h340C1F, -1, 1'b1);

        // Reset during the second byte
        wait_ready(ok);
        set_mask(-1);
        data  = 24'h340C1F;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rises >= 12) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_byte2", 32'(ok), 32'd1);
        d0 = done_cnt;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_scl", 32'(scl), 32'd1);
        chk("mid_rst_oe", 32'(sda_oe), 32'd0);
        chk("mid_rst_en", 32'(enable_clk), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("mid_rst_nodone", 32'(done_cnt - d0), 32'd0);

        // Back-to-back with start held high
        wait_ready(ok);
        s0 = starts;
        set_mask(-1);
        data  = 24'hA5_3C_81;
        start = 1'b1;
        @(posedge clk);
        #1;
        data = 24'h5A_C3_7E;
        wait_done(ok);
        chk("b2b_done1", 32'(ok), 32'd1);
        check_tx(24'hA53C81, -1);
        @(negedge clk);
        chk("b2b_ready", 32'(ready), 32'd1);
        @(negedge clk);
        chk("b2b_accept_en", 32'(enable_clk), 32'd1);
        chk("b2b_accept_rdy", 32'(ready), 32'd0);
        start = 1'b0;
        wait_done(ok);
        chk("b2b_done2", 32'(ok), 32'd1);
        check_tx(24'h5AC37E, -1);
        chk("b2b_starts", 32'(starts - s0), 32'd2);

        // Random data and NACK position
        for (int k = 0; k < 5; k++) begin
            r = $urandom;
            do_tx(r[W-1:0], int'($urandom_range(0, 3)) - 1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
